// File: rtl/instr_loader.sv
// Writable 128-byte instruction memory loaded from a big-endian byte stream; combinational fetch read port.
// Latency: a byte accepted at edge T is visible on instr after T; done pulses the cycle after the last transfer.
// Backpressure: byteReady is high only in LOAD; in LOAD every valid byte is accepted, gaps stall without timeout.
module instr_loader #(
  parameter int MEM_BYTES = 128,
  parameter int ADRS_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        loadLen,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADRS_W-1:0] progAdrs,
  output logic [7:0]        checksum,
  input  logic [ADRS_W-1:0] readAdrs,
  output logic [31:0]       instr,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  mem [MEM_BYTES];
  // Pointer is one bit wider than the address so a full 32-word load can reach 128.
  logic [7:0]  ptr;
  logic [7:0]  target;
  logic [7:0]  csum;
  logic        err_q;
  logic        rdy_q;
  logic        busy_q;
  logic        done_q;
  logic        len_ok;
  logic        xfer;
  logic [ADRS_W-1:0] a1, a2, a3;

  assign len_ok = (loadLen != 6'd0) && (loadLen <= 6'd32);
  assign xfer   = (state == LOAD) && byteValid;

  // Byte storage: cleared on reset, written on every accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (xfer) begin
      mem[ptr[ADRS_W-1:0]] <= byteIn;
    end
  end

  // Session FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 8'd0;
      target <= 8'd0;
      csum   <= 8'd0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state  <= LOAD;
              ptr    <= 8'd0;
              target <= {loadLen, 2'b00};
              csum   <= 8'd0;
              err_q  <= 1'b0;
              rdy_q  <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              // Illegal length: flag it, leave memory, pointer and checksum alone.
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // start is deliberately ignored here; the session length is locked.
          if (byteValid) begin
            ptr  <= ptr + 8'd1;
            csum <= csum + byteIn;
            if (ptr == target - 8'd1) begin
              state  <= DONE;
              rdy_q  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign byteReady = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign progAdrs  = ptr[ADRS_W-1:0];
  assign checksum  = csum;

  // Fetch read port: big-endian word, address arithmetic wraps at the memory size.
  assign a1 = readAdrs + ADRS_W'(1);
  assign a2 = readAdrs + ADRS_W'(2);
  assign a3 = readAdrs + ADRS_W'(3);

  assign instr = {mem[readAdrs], mem[a1], mem[a2], mem[a3]};
  assign rd    = instr[11:7];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: model memory plus a queue of expected fetch words.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: the driver only counts a byte as sent when byteReady was high for it.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  loadLen;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  progAdrs;
  logic [7:0]  checksum;
  logic [6:0]  readAdrs;
  logic [31:0] instr;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [128];
  logic [7:0]  stim [128];
  logic [31:0] exp_q [$];
  int          exp_ptr;
  logic [7:0]  exp_sum;
  logic        exp_err;
  int          last_cycles;

  always #5 clk = ~clk;

  instr_loader #(.MEM_BYTES(128), .ADRS_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .loadLen(loadLen),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .busy(busy), .done(done), .err(err), .progAdrs(progAdrs),
    .checksum(checksum), .readAdrs(readAdrs), .instr(instr),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    exp_ptr = 0;
    exp_sum = 8'h00;
    exp_err = 1'b0;
  endtask

  // Push the model's word for adrs, drive the address, then pop and compare.
  task automatic read_check(input logic [6:0] adrs);
    logic [31:0] w;
    logic [31:0] got;
    logic [6:0]  b1, b2, b3;
    b1 = adrs + 7'd1;
    b2 = adrs + 7'd2;
    b3 = adrs + 7'd3;
    exp_q.push_back({model_mem[adrs], model_mem[b1], model_mem[b2], model_mem[b3]});
    readAdrs = adrs;
    #1;
    w = exp_q.pop_front();
    got = instr;
    check("instr", got, w);
    check("rd",  32'(rd),  32'(w[11:7]));
    check("rs1", 32'(rs1), 32'(w[19:15]));
    check("rs2", 32'(rs2), 32'(w[24:20]));
  endtask

  task automatic do_start(input logic [5:0] len);
    @(negedge clk);
    start   = 1'b1;
    loadLen = len;
    @(negedge clk);
    start   = 1'b0;
    if (len != 6'd0 && len <= 6'd32) begin
      exp_ptr = 0;
      exp_sum = 8'h00;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Stream n bytes from stim; optional 1-0 gaps; optional mid-session start pulse at byte ms_idx.
  task automatic send_bytes(input int n, input bit gaps, input int ms_idx);
    int  i = 0;
    int  cyc = 0;
    bit  idle_slot = 1'b0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      check("progAdrs_step", 32'(progAdrs), 32'(exp_ptr % 128));
      if (gaps && idle_slot) begin
        byteValid = 1'b0;
      end else begin
        byteValid = 1'b1;
        byteIn    = stim[i];
        if (i == ms_idx) begin
          start   = 1'b1;
          loadLen = 6'd5;
        end
        if (byteReady) begin
          model_mem[exp_ptr % 128] = stim[i];
          exp_sum = exp_sum + stim[i];
          exp_ptr++;
          i++;
        end
      end
      idle_slot = ~idle_slot;
    end
    if (cyc >= 2000) check("stream_timeout", 32'(i), 32'(n));
    last_cycles = cyc;
  endtask

  // The cycle after the last transfer edge must be the single done cycle.
  task automatic finish_session();
    @(negedge clk);
    byteValid = 1'b0;
    start     = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("ready_in_done", 32'(byteReady), 32'd0);
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("progAdrs_end", 32'(progAdrs), 32'(exp_ptr % 128));
    @(negedge clk);
    check("done_low", 32'(done), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] prog [24];
    prog = '{8'h00, 8'h60, 8'h01, 8'h93, 8'h00, 8'h40, 8'h02, 8'h13,
             8'h00, 8'h32, 8'h02, 8'h33, 8'h00, 8'h40, 8'h20, 8'h23,
             8'h00, 8'h00, 8'h22, 8'h83, 8'h00, 8'h52, 8'h00, 8'h63};
    rst = 1'b1; start = 1'b0; loadLen = 6'd0; byteIn = 8'h00;
    byteValid = 1'b0; readAdrs = 7'd0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_ready", 32'(byteReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_progAdrs", 32'(progAdrs), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    read_check(7'd0);

    // Back-to-back 6-word load.
    for (int i = 0; i < 24; i++) stim[i] = prog[i];
    do_start(6'd6);
    check("ready_after_start", 32'(byteReady), 32'd1);
    send_bytes(24, 1'b0, -1);
    check("b2b_cycles", 32'(last_cycles), 32'd24);
    finish_session();
    check("checksum_8d", 32'(checksum), 32'h8D);
    read_check(7'd0);
    check("instr0_const", instr, 32'h00600193);
    check("rd0_const", 32'(rd), 32'd3);
    check("rs2_0_const", 32'(rs2), 32'd6);
    read_check(7'd8);
    check("instr8_const", instr, 32'h00320233);
    check("rs1_8_const", 32'(rs1), 32'd4);

    // Same stream with a 1-0 valid pattern.
    do_start(6'd6);
    check("checksum_cleared", 32'(checksum), 32'd0);
    send_bytes(24, 1'b1, -1);
    finish_session();
    check("gap_checksum", 32'(checksum), 32'h8D);
    for (int a = 0; a < 24; a += 4) read_check(7'(a));

    // Illegal lengths.
    do_start(6'd0);
    check("err_len0", 32'(err), 32'd1);
    check("busy_len0", 32'(busy), 32'd0);
    do_start(6'd33);
    check("err_len33", 32'(err), 32'd1);
    check("busy_len33", 32'(busy), 32'd0);
    check("ready_len33", 32'(byteReady), 32'd0);
    check("cs_hold", 32'(checksum), 32'h8D);
    check("progAdrs_hold", 32'(progAdrs), 32'd24);
    read_check(7'd4);

    // Full 32-word load, wrap-around read.
    for (int i = 0; i < 128; i++) stim[i] = 8'(i);
    stim[124] = 8'hAA; stim[125] = 8'hBB; stim[126] = 8'hCC; stim[127] = 8'hDD;
    do_start(6'd32);
    check("err_cleared", 32'(err), 32'(exp_err));
    send_bytes(128, 1'b0, -1);
    finish_session();
    check("progAdrs_wrap", 32'(progAdrs), 32'd0);
    read_check(7'd126);
    check("instr126_const", instr, 32'hCCDD0001);
    read_check(7'd60);

    // start pulsed mid-session must not change the length.
    for (int i = 0; i < 8; i++) stim[i] = 8'h10 + 8'(i);
    do_start(6'd2);
    send_bytes(8, 1'b0, 3);
    finish_session();
    check("midstart_len", 32'(progAdrs), 32'd8);
    read_check(7'd0);
    read_check(7'd4);
    read_check(7'd8);

    // Reset mid-load discards the in-flight byte and clears everything.
    for (int i = 0; i < 24; i++) stim[i] = prog[i];
    do_start(6'd6);
    send_bytes(10, 1'b0, -1);
    @(negedge clk);
    byteValid = 1'b1;
    byteIn    = 8'hFF;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    byteValid = 1'b0;
    model_clear();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(byteReady), 32'd0);
    check("mid_rst_checksum", 32'(checksum), 32'd0);
    check("mid_rst_progAdrs", 32'(progAdrs), 32'd0);
    for (int a = 0; a < 128; a++) read_check(7'(a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
